scan_master: RTL and testbench
==============================

Name: scan_master

Overview:
- Host-side driver for the on-chip 51-bit scan chain, i.e. the initiator end of the scan pad protocol: it drives scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain and scan_id, and samples scan_data_out.
- Accepts one read/write command over a valid/ready interface and runs the full sequence: serialise the frame, load it into the chip, pulse scan_id, wait, capture the chain, shift it out, then return rdata and status.
- Used in the FPGA test harness and in the chip-level bench to exercise SRAM, control-register and SIMD lane accesses.

Parameters:
- PHASE_CYCLES, 2, clk cycles each of scan_phi / scan_phi_bar is held high (minimum 1).
- GAP_CYCLES, 1, non-overlap clk cycles after each phase falls (minimum 1).
- LOAD_CYCLES, 2, width in clk cycles of the scan_load_chip pulse and of the scan_id pulse.
- WAIT_CYCLES, 16, clk cycles from scan_id falling to the start of chain capture.
- MAX_RETRY, 3, extra capture attempts made while the captured ready bit is 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only
- cmd_wen  in  1  write enable
- cmd_ren  in  1  read enable
- cmd_addr  in  16  target address
- cmd_wdata  in  16  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response accepted
- rsp_rdata  out  16  captured rdata
- rsp_timeout  out  1  ready bit still 0 after all retries
- rsp_mismatch  out  1  echo-check failure (see Optional Feature)
- busy  out  1  high whenever the FSM is not in IDLE
- scan_id  out  1  transaction strobe to the chip
- scan_phi  out  1  shift phase 1
- scan_phi_bar  out  1  shift phase 2
- scan_data_in  out  1  serial data to the chip
- scan_data_out  in  1  serial data from the chip
- scan_load_chip  out  1  chain-to-chip load strobe
- scan_load_chain  out  1  chip-to-chain capture strobe

Behaviour:
Clock and reset:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- On reset every output goes to 0 except cmd_ready=1. The FSM goes to IDLE and the shift, retry and bit counters clear.
- Reset asserted mid-transaction aborts immediately: phi, phi_bar and all strobes drop to 0 in the same instant, and no response is produced.
- All outputs are registered.

Frame (51 bits):
- bit0 = wen, bit1 = ren, [17:2] = addr, [33:18] = wdata, [49:34] = rdata, bit50 = ready.
- Shift-in sends bit50 first and bit0 last. The rdata and ready fields are sent as 0.

Bit cell (one shifted bit):
- scan_data_in is set at the start of the cell and held for the whole cell.
- scan_phi is high for PHASE_CYCLES, then low for GAP_CYCLES.
- scan_phi_bar is high for PHASE_CYCLES, then low for GAP_CYCLES.
- Cell length is 2*(PHASE_CYCLES+GAP_CYCLES) clks.
- scan_data_out is sampled on the clk where scan_phi_bar falls.
- scan_phi and scan_phi_bar are never high together.

FSM states and transitions:
- IDLE: when cmd_valid is high, latch the command and go to SHIFT_IN. cmd_ready=1 in this state only.
- SHIFT_IN: 51 bit cells, then LOAD.
- LOAD: scan_load_chip high for LOAD_CYCLES, then GAP_CYCLES low, then STROBE.
- STROBE: scan_id high for LOAD_CYCLES, then WAIT.
- WAIT: count WAIT_CYCLES, then CAPTURE.
- CAPTURE: scan_load_chain high for one full bit cell (one phi/phi_bar pair), then low, then SHIFT_OUT.
- SHIFT_OUT: 51 bit cells with scan_data_in=0. Captured bits fill a shadow register in bit50-first order.
- CHECK:
  - ready bit = 1: go to RESP.
  - ready bit = 0 and retry < MAX_RETRY: increment retry, go to WAIT.
  - ready bit = 0 and retries exhausted: set rsp_timeout, go to RESP.
- RESP: rsp_valid=1. rsp_rdata, rsp_timeout and rsp_mismatch are held stable until rsp_ready is high; then go to IDLE.

Response timing and boundary cases:
- Response handshake: if rsp_ready is high on the first RESP cycle, rsp_valid is high for exactly one cycle.
- cmd_wen=cmd_ren=0: the frame is still issued. The chip ignores it, and the response returns whatever it captures.
- cmd_wen=cmd_ren=1: passed through unchanged. Arbitration is the chip's concern.
- rsp_rdata is reported regardless of the ready bit.
- MAX_RETRY=0: exactly one capture is made.

Optional Feature:
- Macro: SCAN_MASTER_ECHO_CHECK_EN.
- With the macro defined: in CHECK (final attempt only), compare captured bits [33:0] against the latched command. Set rsp_mismatch=1 on any difference. rsp_timeout is unaffected.
- Without the macro: rsp_mismatch is tied to 0 and no comparator is built.

Test Plan:
- Reset with rst_n=0 at t=3 clks, mid-SHIFT_IN: all scan outputs read 0 within the same cycle, cmd_ready=1, busy=0, and no rsp_valid follows.
- Write wen=1, addr=0x0123, wdata=0xBEEF with the chip model returning ready=1 (defaults): scan_data_in serial stream equals the frame from bit50 down to bit0, 6 clks per bit. scan_phi/scan_phi_bar never overlap. One rsp_valid, rsp_timeout=0.
- Read ren=1, addr=0x0800, model rdata=0xA5C3, ready=1: rsp_rdata=0xA5C3. Time from cmd accept to rsp_valid matches the cycle count implied by the defaults.
- Model ready stays 0: exactly 4 CAPTURE pulses, then rsp_timeout=1. Model ready=1 on the 2nd capture: 2 captures and rsp_timeout=0.
- Hold rsp_ready=0 for 10 cycles: rsp_valid and rsp_rdata stay stable and cmd_ready=0. A new cmd_valid is not accepted until the cycle after rsp_ready is high.
- With SCAN_MASTER_ECHO_CHECK_EN, model corrupts captured addr bit5: rsp_mismatch=1. Without the macro the same case gives rsp_mismatch=0.

Source files
------------

// File: rtl/scan_master.sv
// Host-side scan chain initiator: serialises a 51-bit frame, loads it, strobes scan_id, captures and shifts back.
// Optional echo comparison of the captured command fields is enabled by SCAN_MASTER_ECHO_CHECK_EN.
`timescale 1ns/1ps
module scan_master #(
    parameter int PHASE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1,
    parameter int LOAD_CYCLES  = 2,
    parameter int WAIT_CYCLES  = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wen,
    input  logic        cmd_ren,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        rsp_mismatch,
    output logic        busy,
    output logic        scan_id,
    output logic        scan_phi,
    output logic        scan_phi_bar,
    output logic        scan_data_in,
    input  logic        scan_data_out,
    output logic        scan_load_chip,
    output logic        scan_load_chain
);
    localparam int CW = 16;
    localparam logic [CW-1:0] PHI_END     = CW'(PHASE_CYCLES);
    localparam logic [CW-1:0] BAR_START   = CW'(PHASE_CYCLES + GAP_CYCLES);
    localparam logic [CW-1:0] BAR_END     = CW'(2 * PHASE_CYCLES + GAP_CYCLES);
    localparam logic [CW-1:0] SAMPLE_AT   = CW'(2 * PHASE_CYCLES + GAP_CYCLES - 1);
    localparam logic [CW-1:0] CELL_LAST   = CW'(2 * (PHASE_CYCLES + GAP_CYCLES) - 1);
    localparam logic [CW-1:0] LOAD_HIGH   = CW'(LOAD_CYCLES);
    localparam logic [CW-1:0] LOAD_LAST   = CW'(LOAD_CYCLES + GAP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST   = CW'(WAIT_CYCLES - 1);
    localparam logic [7:0]    RETRY_MAX   = 8'(MAX_RETRY);
    localparam logic [5:0]    LAST_BIT    = 6'd50;

    typedef enum logic [3:0] {
        S_IDLE, S_SHIFT_IN, S_LOAD, S_STROBE, S_WAIT,
        S_CAPTURE, S_SHIFT_OUT, S_CHECK, S_RESP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cyc_cnt, cyc_n;
    logic [5:0]    bit_cnt, bit_n;
    logic [7:0]    retry_cnt, retry_n;
    logic [50:0]   tx_sr, tx_n;
    logic [50:0]   shadow, shadow_n;
    logic [15:0]   rdata_n;
    logic          timeout_n;
    logic          cell_end, final_check, in_cell;
    logic          phi_n, bar_n, din_n, load_chip_n, load_chain_n, id_n;
`ifdef SCAN_MASTER_ECHO_CHECK_EN
    logic [33:0]   cmd_frame, cmd_n;
    logic          mismatch_q, mismatch_n;
    assign rsp_mismatch = mismatch_q;
`else
    assign rsp_mismatch = 1'b0;
`endif

    // Next-state, counters and the next value of every registered output.
    always_comb begin
        state_n     = state;
        cyc_n       = cyc_cnt;
        bit_n       = bit_cnt;
        retry_n     = retry_cnt;
        tx_n        = tx_sr;
        shadow_n    = shadow;
        rdata_n     = rsp_rdata;
        timeout_n   = rsp_timeout;
        final_check = 1'b0;
        cell_end    = (cyc_cnt == CELL_LAST);
`ifdef SCAN_MASTER_ECHO_CHECK_EN
        cmd_n       = cmd_frame;
        mismatch_n  = mismatch_q;
`endif
        case (state)
            S_IDLE: begin
                cyc_n   = '0;
                bit_n   = '0;
                retry_n = '0;
                if (cmd_valid) begin
                    tx_n      = {17'b0, cmd_wdata, cmd_addr, cmd_ren, cmd_wen};
                    timeout_n = 1'b0;
`ifdef SCAN_MASTER_ECHO_CHECK_EN
                    cmd_n      = {cmd_wdata, cmd_addr, cmd_ren, cmd_wen};
                    mismatch_n = 1'b0;
`endif
                    state_n = S_SHIFT_IN;
                end
            end
            S_SHIFT_IN: begin
                if (cell_end) begin
                    cyc_n = '0;
                    tx_n  = {tx_sr[49:0], 1'b0};
                    if (bit_cnt == LAST_BIT) begin
                        bit_n   = '0;
                        state_n = S_LOAD;
                    end else begin
                        bit_n = bit_cnt + 6'd1;
                    end
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
            S_LOAD: begin
                if (cyc_cnt == LOAD_LAST) begin
                    cyc_n   = '0;
                    state_n = S_STROBE;
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
            S_STROBE: begin
                if (cyc_cnt == STROBE_LAST) begin
                    cyc_n   = '0;
                    state_n = S_WAIT;
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (cyc_cnt == WAIT_LAST) begin
                    cyc_n   = '0;
                    state_n = S_CAPTURE;
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                if (cell_end) begin
                    cyc_n   = '0;
                    bit_n   = '0;
                    state_n = S_SHIFT_OUT;
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
            S_SHIFT_OUT: begin
                // The chip advances its chain as phi_bar falls, so sample the old bit on that edge.
                if (cyc_cnt == SAMPLE_AT)
                    shadow_n = {shadow[49:0], scan_data_out};
                if (cell_end) begin
                    cyc_n = '0;
                    if (bit_cnt == LAST_BIT) begin
                        bit_n   = '0;
                        state_n = S_CHECK;
                    end else begin
                        bit_n = bit_cnt + 6'd1;
                    end
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
            S_CHECK: begin
                if (shadow[50]) begin
                    final_check = 1'b1;
                    state_n     = S_RESP;
                end else if (retry_cnt < RETRY_MAX) begin
                    retry_n = retry_cnt + 8'd1;
                    cyc_n   = '0;
                    state_n = S_WAIT;
                end else begin
                    final_check = 1'b1;
                    timeout_n   = 1'b1;
                    state_n     = S_RESP;
                end
                if (final_check) begin
                    rdata_n = shadow[49:34];
`ifdef SCAN_MASTER_ECHO_CHECK_EN
                    mismatch_n = (shadow[33:0] != cmd_frame);
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        in_cell      = (state_n == S_SHIFT_IN) || (state_n == S_CAPTURE) || (state_n == S_SHIFT_OUT);
        phi_n        = in_cell && (cyc_n < PHI_END);
        bar_n        = in_cell && (cyc_n >= BAR_START) && (cyc_n < BAR_END);
        din_n        = (state_n == S_SHIFT_IN) && tx_n[50];
        load_chip_n  = (state_n == S_LOAD) && (cyc_n < LOAD_HIGH);
        load_chain_n = (state_n == S_CAPTURE);
        id_n         = (state_n == S_STROBE);
    end

    // Registered state and outputs; reset drops every strobe and phase at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cyc_cnt         <= '0;
            bit_cnt         <= '0;
            retry_cnt       <= '0;
            tx_sr           <= '0;
            shadow          <= '0;
            cmd_ready       <= 1'b1;
            busy            <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_timeout     <= 1'b0;
            scan_id         <= 1'b0;
            scan_phi        <= 1'b0;
            scan_phi_bar    <= 1'b0;
            scan_data_in    <= 1'b0;
            scan_load_chip  <= 1'b0;
            scan_load_chain <= 1'b0;
        end else begin
            state           <= state_n;
            cyc_cnt         <= cyc_n;
            bit_cnt         <= bit_n;
            retry_cnt       <= retry_n;
            tx_sr           <= tx_n;
            shadow          <= shadow_n;
            cmd_ready       <= (state_n == S_IDLE);
            busy            <= (state_n != S_IDLE);
            rsp_valid       <= (state_n == S_RESP);
            rsp_rdata       <= rdata_n;
            rsp_timeout     <= timeout_n;
            scan_id         <= id_n;
            scan_phi        <= phi_n;
            scan_phi_bar    <= bar_n;
            scan_data_in    <= din_n;
            scan_load_chip  <= load_chip_n;
            scan_load_chain <= load_chain_n;
        end
    end

`ifdef SCAN_MASTER_ECHO_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_frame  <= '0;
            mismatch_q <= 1'b0;
        end else begin
            cmd_frame  <= cmd_n;
            mismatch_q <= mismatch_n;
        end
    end
`endif
endmodule

// File: tb/tb_scan_master.sv
// Directed bench for scan_master with a behavioural scan-chain chip model.
`timescale 1ns/1ps
module tb_scan_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wen = 1'b0;
    logic        cmd_ren = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_timeout;
    logic        rsp_mismatch;
    logic        busy;
    logic        scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_data_out;
    logic        scan_load_chip, scan_load_chain;

    int checks = 0;
    int failures = 0;

`ifdef SCAN_MASTER_ECHO_CHECK_EN
    localparam logic ECHO_EXP = 1'b1;
`else
    localparam logic ECHO_EXP = 1'b0;
`endif

    scan_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wen(cmd_wen), .cmd_ren(cmd_ren),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .rsp_mismatch(rsp_mismatch), .busy(busy),
        .scan_id(scan_id), .scan_phi(scan_phi), .scan_phi_bar(scan_phi_bar),
        .scan_data_in(scan_data_in), .scan_data_out(scan_data_out),
        .scan_load_chip(scan_load_chip), .scan_load_chain(scan_load_chain)
    );

    always #5 clk = ~clk;

    // Chip model: chain shifts on phi_bar falling, parallel-loads the response when load_chain is high.
    logic [50:0] chain = '0;
    logic [50:0] in_frame = '0;
    logic [15:0] m_rdata = '0;
    int          m_ready_on = 1;
    logic        m_corrupt = 1'b0;
    int          cap_count = 0;
    int          cap_base = 0;
    int          overlap_cnt = 0;
    int          rsp_seen = 0;
    logic        model_ready;

    assign scan_data_out = chain[50];
    assign model_ready = (m_ready_on != 0) && ((cap_count - cap_base) >= m_ready_on);

    always @(posedge scan_load_chain) cap_count++;
    always @(posedge scan_load_chip) in_frame <= chain;
    always @(negedge scan_phi_bar) begin
        if (scan_load_chain)
            chain <= {model_ready, m_rdata, in_frame[33:0] ^ (m_corrupt ? 34'h80 : 34'h0)};
        else
            chain <= {chain[49:0], scan_data_in};
    end
    always @(posedge clk) begin
        if (scan_phi && scan_phi_bar) overlap_cnt++;
        if (rsp_valid) rsp_seen++;
    end

    typedef struct {
        logic        wen;
        logic        ren;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mdata;
        int          ready_on;
        logic        corrupt;
        logic [15:0] exp_rdata;
        logic        exp_timeout;
        logic        exp_mismatch;
        int          exp_caps;
        int          exp_lat;
    } vec_t;
    vec_t vecs[7];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic wait_rsp(output int n, input int start);
        n = start;
        while (!rsp_valid && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic apply_stimulus(input int idx);
        logic [50:0] exp_frame;
        int stream_err;
        int lat;
        int ovl_base;
        vec_t v;
        v = vecs[idx];
        m_rdata    = v.mdata;
        m_ready_on = v.ready_on;
        m_corrupt  = v.corrupt;
        cap_base   = cap_count;
        ovl_base   = overlap_cnt;
        exp_frame  = {17'b0, v.wdata, v.addr, v.ren, v.wen};
        cmd_wen = v.wen; cmd_ren = v.ren; cmd_addr = v.addr; cmd_wdata = v.wdata;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        stream_err = 0;
        for (int j = 0; j < 306; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            if (scan_data_in !== exp_frame[50 - j / 6]) stream_err++;
        end
        check_output($sformatf("v%0d_stream", idx), 64'(stream_err), 64'd0);
        wait_rsp(lat, 305);
        check_output($sformatf("v%0d_rsp_valid", idx), 64'(rsp_valid), 64'd1);
        check_output($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
        check_output($sformatf("v%0d_rdata", idx), 64'(rsp_rdata), 64'(v.exp_rdata));
        check_output($sformatf("v%0d_timeout", idx), 64'(rsp_timeout), 64'(v.exp_timeout));
        check_output($sformatf("v%0d_mismatch", idx), 64'(rsp_mismatch), 64'(v.exp_mismatch));
        check_output($sformatf("v%0d_captures", idx), 64'(cap_count - cap_base), 64'(v.exp_caps));
        check_output($sformatf("v%0d_chip_frame", idx), 64'(in_frame), 64'(exp_frame));
        check_output($sformatf("v%0d_overlap", idx), 64'(overlap_cnt - ovl_base), 64'd0);
        @(posedge clk); #1;
        check_output($sformatf("v%0d_valid_one_cycle", idx), 64'(rsp_valid), 64'd0);
        check_output($sformatf("v%0d_ready_again", idx), 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int n;
        int hold_err;
        int seen_base;
        vecs[0] = '{1'b1, 1'b0, 16'h0123, 16'hBEEF, 16'h0000, 1, 1'b0, 16'h0000, 1'b0, 1'b0, 1, 640};
        vecs[1] = '{1'b0, 1'b1, 16'h0800, 16'h0000, 16'hA5C3, 1, 1'b0, 16'hA5C3, 1'b0, 1'b0, 1, 640};
        vecs[2] = '{1'b0, 1'b1, 16'h0042, 16'h0000, 16'h1111, 0, 1'b0, 16'h1111, 1'b1, 1'b0, 4, 1627};
        vecs[3] = '{1'b0, 1'b1, 16'h0043, 16'h0000, 16'h2222, 2, 1'b0, 16'h2222, 1'b0, 1'b0, 2, 969};
        vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 16'h5555, 16'h7E7E, 1, 1'b0, 16'h7E7E, 1'b0, 1'b0, 1, 640};
        vecs[5] = '{1'b1, 1'b1, 16'h8001, 16'h1234, 16'h4321, 1, 1'b0, 16'h4321, 1'b0, 1'b0, 1, 640};
        vecs[6] = '{1'b1, 1'b0, 16'h0010, 16'h00FF, 16'h0000, 1, 1'b1, 16'h0000, 1'b0, ECHO_EXP, 1, 640};

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_outputs",
            64'({rsp_valid, rsp_timeout, rsp_mismatch, scan_id, scan_phi, scan_phi_bar,
                 scan_data_in, scan_load_chip, scan_load_chain}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) apply_stimulus(i);

        // Response back-pressure: hold rsp_ready low with a new command already pending.
        m_rdata = 16'h3C3C; m_ready_on = 1; m_corrupt = 1'b0; cap_base = cap_count;
        cmd_wen = 1'b0; cmd_ren = 1'b1; cmd_addr = 16'h0200; cmd_wdata = 16'h0000;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rsp(n, 0);
        check_output("hold_rsp_valid", 64'(rsp_valid), 64'd1);
        cmd_wen = 1'b1; cmd_ren = 1'b0; cmd_addr = 16'h0300; cmd_wdata = 16'h0F0F;
        cmd_valid = 1'b1;
        hold_err = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h3C3C || cmd_ready !== 1'b0) hold_err++;
        end
        check_output("hold_stable", 64'(hold_err), 64'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_output("release_valid", 64'(rsp_valid), 64'd0);
        check_output("release_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        check_output("second_accept", 64'({cmd_ready, busy}), 64'b01);
        cmd_valid = 1'b0;
        wait_rsp(n, 0);
        check_output("second_rsp_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;

        // Reset in the middle of SHIFT_IN, while phi_bar is high.
        cmd_wen = 1'b1; cmd_ren = 1'b0; cmd_addr = 16'hFFFF; cmd_wdata = 16'hFFFF;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("pre_reset_phi_bar", 64'(scan_phi_bar), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("abort_scan_outputs",
            64'({scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain}), 64'd0);
        check_output("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        check_output("abort_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_base = rsp_seen;
        repeat (700) @(posedge clk);
        #1;
        check_output("abort_no_rsp", 64'(rsp_seen - seen_base), 64'd0);
        check_output("abort_idle", 64'({cmd_ready, busy}), 64'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
